// File: rtl/jerky_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : jerky_decoder
//  Purpose  : Two-stage decoder for a one-hot "jerky" up/down counter.
//             Stage 1 registers the raw sample; stage 2 checks that it is
//             one-hot, reports the bit position and tracks full up/down
//             sweeps (IDLE -> RISING -> FALLING -> RISING ...).
//  Config   : `define JERKY_DEC_SWEEPCNT_EN to build the 8-bit sweep counter;
//             when it is not defined, sweep_cnt is tied to zero.
//  Revision : 1.0  initial release
// ============================================================================
module jerky_decoder #(
    parameter int COUNTER_SIZE = 5,
    parameter int IDX_W        = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [COUNTER_SIZE-1:0] count,
    output logic [IDX_W-1:0]        idx,
    output logic                    idx_valid,
    output logic                    onehot_err,
    output logic                    peak,
    output logic                    sweep_done,
    output logic [7:0]              sweep_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RISING  = 2'd1;
    localparam logic [1:0] FALLING = 2'd2;

    localparam logic [IDX_W-1:0]        TOP_IDX = IDX_W'(COUNTER_SIZE - 1);
    localparam logic [COUNTER_SIZE-1:0] ONE     = COUNTER_SIZE'(1);

    // Stage 1 registers
    logic [COUNTER_SIZE-1:0] s1_count;
    logic                    s1_en;

    // Stage 2 state
    logic [1:0] state;

    // Stage 2 next-state values
    logic [1:0]       nxt_state;
    logic [IDX_W-1:0] nxt_idx;
    logic             nxt_valid;
    logic             nxt_err;
    logic             nxt_peak;
    logic             nxt_done;

    // Decode helpers
    logic             is_onehot;
    logic [IDX_W-1:0] bit_pos;

    // Stage 1: capture the raw upstream sample every cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_count <= '0;
            s1_en    <= 1'b0;
        end else begin
            s1_count <= count;
            s1_en    <= en;
        end
    end

    // One-hot test (x & (x-1) clears the lowest set bit) and bit position
    always_comb begin
        is_onehot = (s1_count != '0) && ((s1_count & (s1_count - ONE)) == '0);
        bit_pos   = '0;
        for (int i = 0; i < COUNTER_SIZE; i++) begin
            if (s1_count[i]) begin
                bit_pos = IDX_W'(i);
            end
        end
    end

    // Stage 2: sweep tracking and output pulse generation
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_valid = 1'b0;
        nxt_err   = 1'b0;
        nxt_peak  = 1'b0;
        nxt_done  = 1'b0;
        if (!s1_en) begin
            // Counter disabled: any sweep in progress is abandoned
            nxt_state = IDLE;
        end else if (!is_onehot) begin
            // Corrupt sample: keep the last good index, restart tracking
            nxt_err   = 1'b1;
            nxt_state = IDLE;
        end else begin
            nxt_idx   = bit_pos;
            nxt_valid = 1'b1;
            case (state)
                IDLE: begin
                    if (bit_pos == '0) begin
                        nxt_state = RISING;
                    end
                end
                RISING: begin
                    if (bit_pos == TOP_IDX) begin
                        nxt_state = FALLING;
                        nxt_peak  = 1'b1;
                    end
                end
                FALLING: begin
                    // Repeated top-bit samples land here and stay silent
                    if (bit_pos == '0) begin
                        nxt_state = RISING;
                        nxt_done  = 1'b1;
                    end
                end
                default: begin
                    nxt_state = IDLE;
                end
            endcase
        end
    end

    // Stage 2 output and state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            idx_valid  <= 1'b0;
            onehot_err <= 1'b0;
            peak       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            idx_valid  <= nxt_valid;
            onehot_err <= nxt_err;
            peak       <= nxt_peak;
            sweep_done <= nxt_done;
        end
    end

`ifdef JERKY_DEC_SWEEPCNT_EN
    logic [7:0] sweep_cnt_q;

    // Completed-sweep counter, advances together with the sweep_done pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sweep_cnt_q <= 8'd0;
        end else if (nxt_done) begin
            sweep_cnt_q <= sweep_cnt_q + 8'd1;
        end
    end

    assign sweep_cnt = sweep_cnt_q;
`else
    assign sweep_cnt = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jerky_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jerky_decoder
//  Purpose  : Self-checking bench for jerky_decoder (COUNTER_SIZE=5).
//             A rule-level reference model predicts every output cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jerky_decoder;

    localparam int N  = 5;
    localparam int IW = 3;

    logic          clk;
    logic          reset;
    logic          en;
    logic [N-1:0]  count;
    logic [IW-1:0] idx;
    logic          idx_valid;
    logic          onehot_err;
    logic          peak;
    logic          sweep_done;
    logic [7:0]    sweep_cnt;

    jerky_decoder #(.COUNTER_SIZE(N), .IDX_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .count      (count),
        .idx        (idx),
        .idx_valid  (idx_valid),
        .onehot_err (onehot_err),
        .peak       (peak),
        .sweep_done (sweep_done),
        .sweep_cnt  (sweep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: sweep phase 0 = not tracking, 1 = climbing, 2 = descending
    int       m_phase;
    int       m_idx;
    int       m_cnt;
    logic     p_en;
    logic [N-1:0] p_count;
    int       seen_peak;
    int       seen_done;

`ifdef JERKY_DEC_SWEEPCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic [N-1:0] stream [16];

    task automatic model_reset();
        m_phase = 0;
        m_idx   = 0;
        m_cnt   = 0;
        p_en    = 1'b0;
        p_count = '0;
    endtask

    // One clock: present (e,c), then check outputs produced from the previous sample
    task automatic step(input logic e, input logic [N-1:0] c);
        int ones, pos;
        logic x_valid, x_err, x_peak, x_done;
        @(negedge clk);
        en    = e;
        count = c;
        @(posedge clk);
        #1;
        ones = $countones(p_count);
        pos  = 0;
        for (int i = 0; i < N; i++) if (p_count[i]) pos = i;
        x_valid = 1'b0; x_err = 1'b0; x_peak = 1'b0; x_done = 1'b0;
        if (!p_en) begin
            m_phase = 0;
        end else if (ones != 1) begin
            x_err   = 1'b1;
            m_phase = 0;
        end else begin
            x_valid = 1'b1;
            m_idx   = pos;
            if (m_phase == 0 && pos == 0) m_phase = 1;
            else if (m_phase == 1 && pos == N - 1) begin
                m_phase = 2; x_peak = 1'b1;
            end else if (m_phase == 2 && pos == 0) begin
                m_phase = 1; x_done = 1'b1;
                m_cnt   = (m_cnt + 1) % 256;
            end
        end
        vectors++;
        if (idx !== IW'(m_idx)) begin
            miscompares++; $display("FAIL idx: got %0d expected %0d at %0t", idx, m_idx, $time);
        end
        if (idx_valid !== x_valid) begin
            miscompares++; $display("FAIL idx_valid: got %b expected %b at %0t", idx_valid, x_valid, $time);
        end
        if (onehot_err !== x_err) begin
            miscompares++; $display("FAIL onehot_err: got %b expected %b at %0t", onehot_err, x_err, $time);
        end
        if (peak !== x_peak) begin
            miscompares++; $display("FAIL peak: got %b expected %b at %0t", peak, x_peak, $time);
        end
        if (sweep_done !== x_done) begin
            miscompares++; $display("FAIL sweep_done: got %b expected %b at %0t", sweep_done, x_done, $time);
        end
        if (sweep_cnt !== (CNT_ON ? 8'(m_cnt) : 8'd0)) begin
            miscompares++; $display("FAIL sweep_cnt: got %0d expected %0d at %0t", sweep_cnt, CNT_ON ? m_cnt : 0, $time);
        end
        if (peak === 1'b1) seen_peak++;
        if (sweep_done === 1'b1) seen_done++;
        p_en    = e;
        p_count = c;
    endtask

    // Assert reset between edges, confirm outputs clear at once, release later
    task automatic test_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        en    = 1'b0;
        count = '0;
        #1;
        vectors++;
        if ({idx, idx_valid, onehot_err, peak, sweep_done} !== '0 || sweep_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_async: got idx=%0d v=%b e=%b p=%b d=%b cnt=%0d expected all 0",
                     idx, idx_valid, onehot_err, peak, sweep_done, sweep_cnt);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_stream();
        for (int i = 0; i < 16; i++) step(1'b1, stream[i]);
    endtask

    // Reference sweep: one peak, one sweep_done, checked cycle by cycle
    task automatic test_stream();
        int p0, d0;
        p0 = seen_peak; d0 = seen_done;
        run_stream();
        step(1'b1, 5'b00010);
        vectors++;
        if (seen_peak - p0 != 1 || seen_done - d0 != 1) begin
            miscompares++;
            $display("FAIL stream_pulses: got peak=%0d done=%0d expected 1 and 1", seen_peak - p0, seen_done - d0);
        end
    endtask

    // Corrupt sample mid-sweep, then restart without a sweep_done
    task automatic test_illegal();
        step(1'b1, 5'b00001);
        step(1'b1, 5'b00100);
        step(1'b1, 5'b10000);
        step(1'b1, 5'b00110);
        step(1'b1, 5'b00001);
        step(1'b1, 5'b00010);
        step(1'b1, 5'b00001);
        step(1'b1, 5'b00010);
    endtask

    // All-zero sample with and without enable, plus enable-low holding idx
    task automatic test_zero();
        step(1'b1, 5'b01000);
        step(1'b1, 5'b00000);
        step(1'b0, 5'b00000);
        step(1'b0, 5'b00100);
        step(1'b0, 5'b11111);
        step(1'b1, 5'b00001);
        step(1'b1, 5'b00001);
    endtask

    // 256 sweeps: counter wraps and every sweep_done is seen
    task automatic test_wrap();
        int d0;
        test_reset();
        d0 = seen_done;
        for (int k = 0; k < 256; k++) run_stream();
        step(1'b1, 5'b00010);
        vectors++;
        if (seen_done - d0 != 256) begin
            miscompares++; $display("FAIL wrap_done_count: got %0d expected 256", seen_done - d0);
        end
        vectors++;
        if (sweep_cnt !== 8'd0) begin
            miscompares++; $display("FAIL wrap_cnt: got %0d expected 0", sweep_cnt);
        end
    endtask

    // Reset while descending with three sweeps done; no sweep_done afterwards
    task automatic test_reset_midsweep();
        int d0;
        test_reset();
        for (int k = 0; k < 3; k++) run_stream();
        for (int i = 0; i < 10; i++) step(1'b1, stream[i]);
        test_reset();
        d0 = seen_done;
        step(1'b1, 5'b00001);
        step(1'b1, 5'b00010);
        step(1'b1, 5'b00001);
        step(1'b1, 5'b00100);
        vectors++;
        if (seen_done != d0) begin
            miscompares++; $display("FAIL midsweep_no_done: got %0d pulses expected 0", seen_done - d0);
        end
    endtask

    // Random mix: mostly one-hot walks, some corrupt samples and enable drops
    task automatic test_random();
        int pos;
        logic [N-1:0] c;
        pos = 0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) < 8) begin
                if ($urandom_range(0, 1) == 1) pos = (pos < N - 1) ? pos + 1 : pos - 1;
                else pos = (pos > 0) ? pos - 1 : pos + 1;
                c = '0;
                c[pos] = 1'b1;
            end else begin
                c = N'($urandom);
            end
            step(($urandom_range(0, 19) != 0), c);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        count = '0;
        seen_peak = 0;
        seen_done = 0;
        model_reset();
        stream = '{5'b00001, 5'b00010, 5'b00001, 5'b00100, 5'b00001, 5'b01000,
                   5'b00001, 5'b10000, 5'b10000, 5'b01000, 5'b10000, 5'b00100,
                   5'b10000, 5'b00010, 5'b10000, 5'b00001};
        test_reset();
        step(1'b0, 5'b00000);
        test_stream();
        test_illegal();
        test_zero();
        test_wrap();
        test_reset_midsweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
